// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Lets two requesters share one combinational ALU. Each requester offers one
//   operation at a time over a valid/ready handshake. The arbiter grants the
//   ALU round-robin, registers the winner's operands and select onto the ALU
//   inputs, and gives the ALU one full cycle to settle. It then captures the
//   result and carry and returns them to the winner with a one-cycle response
//   strobe. Each operation takes three cycles (IDLE -> EXEC -> RESP).
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   req0_valid / req1_valid    requester N has an operation pending
//   req0_ready / req1_ready    requester N's operation is accepted this cycle
//   req0_a, req0_b, req0_sel   operands and ALU select of requester 0
//   req1_a, req1_b, req1_sel   operands and ALU select of requester 1
//   alu_a, alu_b, alu_sel      registered operands and select to the ALU
//   alu_out, alu_carry         combinational ALU result and carry-out
//   resp0_valid / resp1_valid  one-cycle strobe, result belongs to requester N
//   resp_data, resp_carry      captured ALU result and carry
//   busy                       an operation is in flight (state is not IDLE)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int SELW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SELW-1:0]  req0_sel,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SELW-1:0]  req1_sel,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,

  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_carry,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_grant;
  logic       owner;
  logic       grant;
  logic       any_valid;
  logic       accept;

  // Grant selection. A lone requester always wins. On a tie the requester
  // that did not win last time wins, so both requesters alternate under load.
  // grant is only meaningful while any_valid is high.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  // Ready is offered only in IDLE, and only to the granted requester. Because
  // grant picks exactly one requester, at most one ready is high at a time.
  assign accept     = (state == IDLE) && any_valid;
  assign req0_ready = accept && req0_valid && !grant;
  assign req1_ready = accept && req1_valid &&  grant;

  // Next-state logic. Every operation spends exactly one cycle in EXEC,
  // waiting for the ALU, and one cycle in RESP, returning the result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Acceptance: register the winner's operation onto the ALU inputs and note
  // who owns it. The ALU inputs are not cleared afterwards. They keep their
  // values until the next acceptance, which keeps the ALU inputs quiet.
  // last_grant resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else if (accept) begin
      alu_a      <= grant ? req1_a   : req0_a;
      alu_b      <= grant ? req1_b   : req0_b;
      alu_sel    <= grant ? req1_sel : req0_sel;
      last_grant <= grant;
      owner      <= grant;
    end
  end

  // Result capture at the end of the EXEC cycle. The ALU has had a full cycle
  // to settle on the registered inputs. The captured values hold until the
  // next operation's capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data  <= '0;
      resp_carry <= 1'b0;
    end else if (state == EXEC) begin
      resp_data  <= alu_out;
      resp_carry <= alu_carry;
    end
  end

  // The response strobes decode directly from the RESP state, so they last
  // exactly one cycle and go only to the owner. A reset during EXEC or RESP
  // forces IDLE, which drops the in-flight operation without any strobe.
  assign resp0_valid = (state == RESP) && !owner;
  assign resp1_valid = (state == RESP) &&  owner;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//   Self-checking bench for alu_arbiter. A behavioural ALU drives the DUT's
//   ALU inputs. A reference model kept here tracks the expected outputs from
//   three values: how many cycles remain before the arbiter is free, who won
//   the last grant, and which operation is in flight. Every output is compared
//   against the model on every cycle. Directed scenarios add explicit checks
//   on grant order, grant spacing and captured results.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 16;
  localparam int SELW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SELW-1:0]  req0_sel, req1_sel;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out, resp_data;
  logic [SELW-1:0]  alu_sel;
  logic             alu_carry, resp_carry;
  logic             resp0_valid, resp1_valid, busy;

  int vectors = 0;
  int miscompares = 0;

  alu_arbiter #(.WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_carry(resp_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: sel 0 = A+B, sel 1 = A-B (carry = bit 16), other = A^B.
  function automatic logic [WIDTH:0] aluRef(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [SELW-1:0] s);
    case (s)
      4'h0:    return {1'b0, a} + {1'b0, b};
      4'h1:    return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // The bench's ALU instance, driven from the DUT's registered ALU inputs.
  always_comb {alu_carry, alu_out} = aluRef(alu_a, alu_b, alu_sel);

  // Reference model state.
  int               m_left;
  bit               m_last, m_owner, m_carry, m_acc0, m_acc1;
  logic [WIDTH-1:0] m_a, m_b, m_data;
  logic [SELW-1:0]  m_sel;

  // Observation logs (what the DUT did), checked against fixed expectations.
  int cyc = 0;
  int obs_grant[$];
  int obs_cycle[$];
  int resp0_count, resp1_count, busy_count;

  task automatic modelReset();
    m_left = 0; m_last = 1'b1; m_owner = 1'b0;
    m_a = '0; m_b = '0; m_sel = '0; m_data = '0; m_carry = 1'b0;
    m_acc0 = 1'b0; m_acc1 = 1'b0;
  endtask

  task automatic clearLogs();
    obs_grant.delete(); obs_cycle.delete();
    resp0_count = 0; resp1_count = 0; busy_count = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
               tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] a0,
                               input logic [WIDTH-1:0] b0, input logic [SELW-1:0] s0,
                               input logic v1, input logic [WIDTH-1:0] a1,
                               input logic [WIDTH-1:0] b1, input logic [SELW-1:0] s1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
  endtask

  // One clock cycle, entered and left at a falling edge with the inputs
  // already applied. All outputs are checked against the model, then the
  // model advances over the coming rising edge.
  task automatic runCycle();
    bit any, win;
    #1;
    if (!rst_n) modelReset();
    any = (m_left == 0) && (req0_valid || req1_valid);
    win = (req0_valid && req1_valid) ? !m_last : req1_valid;
    checkOutput("req0_ready", 32'(req0_ready), 32'(any && !win));
    checkOutput("req1_ready", 32'(req1_ready), 32'(any && win));
    checkOutput("busy", 32'(busy), 32'(m_left != 0));
    checkOutput("resp0_valid", 32'(resp0_valid), 32'(m_left == 1 && !m_owner));
    checkOutput("resp1_valid", 32'(resp1_valid), 32'(m_left == 1 && m_owner));
    checkOutput("alu_a", 32'(alu_a), 32'(m_a));
    checkOutput("alu_b", 32'(alu_b), 32'(m_b));
    checkOutput("alu_sel", 32'(alu_sel), 32'(m_sel));
    checkOutput("resp_data", 32'(resp_data), 32'(m_data));
    checkOutput("resp_carry", 32'(resp_carry), 32'(m_carry));
    if (rst_n) begin
      if (req0_ready && req0_valid) begin obs_grant.push_back(0); obs_cycle.push_back(cyc); end
      if (req1_ready && req1_valid) begin obs_grant.push_back(1); obs_cycle.push_back(cyc); end
    end
    if (resp0_valid) resp0_count++;
    if (resp1_valid) resp1_count++;
    if (busy) busy_count++;
    m_acc0 = 1'b0; m_acc1 = 1'b0;
    if (rst_n) begin
      if (m_left == 0) begin
        if (any) begin
          m_a   = win ? req1_a   : req0_a;
          m_b   = win ? req1_b   : req0_b;
          m_sel = win ? req1_sel : req0_sel;
          m_last = win; m_owner = win; m_left = 2;
          m_acc0 = !win; m_acc1 = win;
        end
      end else if (m_left == 2) begin
        {m_carry, m_data} = aluRef(m_a, m_b, m_sel);
        m_left = 1;
      end else begin
        m_left = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (m_left != 0 && n < 10) begin runCycle(); n++; end
    checkOutput("wait_idle_timeout", 32'(m_left), 32'd0);
  endtask

  // Random requester state: a pending operation is held stable until accepted
  // or withdrawn.
  bit               p0, p1;
  logic [WIDTH-1:0] ha0, hb0, ha1, hb1;
  logic [SELW-1:0]  hs0, hs1;

  initial begin
    int base;
    modelReset();
    clearLogs();
    idleInputs();
    @(negedge clk);

    // Reset with random inputs, then release with req0 valid.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                    1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
      runCycle();
    end
    applyStimulus(1'b1, 16'h0ABC, 16'h02BC, 4'h0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    #1 checkOutput("rel_ready0", 32'(req0_ready), 32'd1);
    runCycle();
    idleInputs();
    runCycle();
    #1 checkOutput("rel_resp0", 32'(resp0_valid), 32'd1);
    checkOutput("rel_data", 32'(resp_data), 32'h0D78);
    checkOutput("rel_carry", 32'(resp_carry), 32'd0);
    runCycle();

    // Carry out of a requester-1 addition.
    clearLogs();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 16'hF623, 16'h0A12, 4'h0);
    runCycle();
    idleInputs();
    runCycle();
    #1 checkOutput("carry_data", 32'(resp_data), 32'h0035);
    checkOutput("carry_bit", 32'(resp_carry), 32'd1);
    runCycle();
    runCycle();
    checkOutput("carry_resp1_cnt", 32'(resp1_count), 32'd1);
    checkOutput("carry_resp0_cnt", 32'(resp0_count), 32'd0);

    // Tie from reset: the grants must alternate 0,1,0,1,0,1, three cycles apart.
    rst_n = 1'b0;
    runCycle();
    clearLogs();
    applyStimulus(1'b1, 16'($urandom), 16'($urandom), 4'h0,
                  1'b1, 16'($urandom), 16'($urandom), 4'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      runCycle();
      if (m_acc0) begin req0_a = 16'($urandom); req0_b = 16'($urandom); end
      if (m_acc1) begin req1_a = 16'($urandom); req1_b = 16'($urandom); end
    end
    checkOutput("tie_count", 32'(obs_grant.size()), 32'd6);
    for (int i = 0; i < obs_grant.size() && i < 6; i++) begin
      checkOutput("tie_order", 32'(obs_grant[i]), 32'(i % 2));
      if (i > 0) checkOutput("tie_spacing", 32'(obs_cycle[i] - obs_cycle[i-1]), 32'd3);
    end
    checkOutput("tie_resp0_cnt", 32'(resp0_count), 32'd3);
    checkOutput("tie_resp1_cnt", 32'(resp1_count), 32'd3);
    idleInputs();
    waitIdle();

    // Late arrival: req1 raised during EXEC waits for the next IDLE cycle.
    clearLogs();
    applyStimulus(1'b1, 16'h1234, 16'h0001, 4'h1, 1'b0, '0, '0, '0);
    runCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 16'h7777, 16'h1111, 4'h0);
    for (int i = 0; i < 3; i++) runCycle();
    req1_valid = 1'b0;
    waitIdle();
    checkOutput("late_count", 32'(obs_grant.size()), 32'd2);
    if (obs_grant.size() == 2) begin
      checkOutput("late_first", 32'(obs_grant[0]), 32'd0);
      checkOutput("late_second", 32'(obs_grant[1]), 32'd1);
      checkOutput("late_spacing", 32'(obs_cycle[1] - obs_cycle[0]), 32'd3);
    end

    // Reset during EXEC: outputs clear at once and no response follows.
    clearLogs();
    applyStimulus(1'b1, 16'hAAAA, 16'h5555, 4'h0, 1'b0, '0, '0, '0);
    runCycle();
    idleInputs();
    #2 rst_n = 1'b0;
    #1 checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("midrst_alu_b", 32'(alu_b), 32'd0);
    modelReset();
    runCycle();
    runCycle();
    applyStimulus(1'b1, 16'h0003, 16'h0004, 4'h0, 1'b1, 16'h0005, 16'h0006, 4'h0);
    rst_n = 1'b1;
    runCycle();
    idleInputs();
    waitIdle();
    checkOutput("midrst_resp0_cnt", 32'(resp0_count), 32'd1);
    if (obs_grant.size() > 0) checkOutput("midrst_tie", 32'(obs_grant[0]), 32'd0);
    else checkOutput("midrst_tie_missing", 32'(obs_grant.size()), 32'd1);

    // Withdrawal: req1 is valid only while busy and drops before it can be
    // granted, so only req0 is served, with two busy cycles per operation.
    clearLogs();
    applyStimulus(1'b1, 16'($urandom), 16'($urandom), 4'h0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 12; i++) begin
      req1_valid = (m_left != 0);
      req1_a = 16'($urandom);
      runCycle();
      if (m_acc0) req0_a = 16'($urandom);
    end
    idleInputs();
    checkOutput("wd_req0_grants", 32'(obs_grant.size()), 32'd4);
    base = 0;
    foreach (obs_grant[i]) if (obs_grant[i] == 1) base++;
    checkOutput("wd_req1_grants", 32'(base), 32'd0);
    checkOutput("wd_busy_cycles", 32'(busy_count), 32'(2 * obs_grant.size()));
    waitIdle();

    // Random traffic with legal holds and withdrawals.
    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) begin
        if ($urandom_range(0, 2) == 0) begin
          p0 = 1'b1; ha0 = 16'($urandom); hb0 = 16'($urandom); hs0 = 4'($urandom_range(0, 2));
        end
      end else if ($urandom_range(0, 7) == 0) p0 = 1'b0;
      if (!p1) begin
        if ($urandom_range(0, 2) == 0) begin
          p1 = 1'b1; ha1 = 16'($urandom); hb1 = 16'($urandom); hs1 = 4'($urandom_range(0, 2));
        end
      end else if ($urandom_range(0, 7) == 0) p1 = 1'b0;
      applyStimulus(p0, ha0, hb0, hs0, p1, ha1, hb1, hs1);
      runCycle();
      if (m_acc0) p0 = 1'b0;
      if (m_acc1) p1 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
